fdiv: RTL

//  Single-precision (IEEE-754 binary32) divider, result = input_a / input_b.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_round.sv | 33 +++
 rtl/fdiv.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the binary32 datapath blocks (fmul, fdiv).
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } float_t;

  localparam int unsigned EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] PINF     = 32'h7F80_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ROUND,
    S_DONE
  } fdiv_state_t;

  typedef enum logic [1:0] {
    SP_NONE,
    SP_NAN,
    SP_ZERO,
    SP_INF
  } fdiv_special_t;

endpackage

// File: rtl/fpu_round.sv
// Round-to-nearest-even and binary32 packing with overflow to inf and flush-to-zero.
module fpu_round
  import fpu_pkg::*;
(
  input  logic              sign_i,
  input  logic signed [9:0] exp_i,
  input  logic [23:0]       mant_i,
  input  logic              guard_i,
  input  logic              sticky_i,
  output logic [31:0]       result_o
);

  logic              round_up;
  logic [24:0]       sum;
  logic signed [9:0] exp_adj;
  logic [22:0]       frac;

  always_comb begin
    round_up = guard_i & (sticky_i | mant_i[0]);
    sum      = {1'b0, mant_i} + {24'd0, round_up};
    // a carry out of the mantissa renormalises to 1.0 and bumps the exponent
    exp_adj  = sum[24] ? exp_i + 10'sd1 : exp_i;
    frac     = sum[24] ? sum[23:1] : sum[22:0];
    if (exp_adj >= 10'sd255) begin
      result_o = {sign_i, PINF[30:0]};
    end else if (exp_adj <= 10'sd0) begin
      result_o = {sign_i, 31'd0};
    end else begin
      result_o = {sign_i, exp_adj[7:0], frac};
    end
  end

endmodule

// File: rtl/fdiv.sv
// Iterative restoring binary32 divider, fixed latency 26/UNROLL+2, one op in flight.
module fdiv
  import fpu_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        input_valid,
  output logic [31:0] result,
  output logic        out_valid,
  output logic        busy
);

  localparam int unsigned ITERS = 26 / UNROLL;

  fdiv_state_t       state_q;
  fdiv_special_t     spec_q, spec_d;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       mb_q;
  logic [25:0]       quo_q, quo_d;
  logic [4:0]        cnt_q;
  logic [31:0]       result_q;
  logic              out_valid_q;
  logic              busy_q;

  float_t fa, fb;
  assign fa = input_a;
  assign fb = input_b;

  always_comb begin
    spec_d = SP_NONE;
    if ((fa.exp == 8'hFF) || (fb.exp == 8'hFF) || ((fa.exp == 8'h00) && (fb.exp == 8'h00)))
      spec_d = SP_NAN;
    else if (fa.exp == 8'h00)
      spec_d = SP_ZERO;
    else if (fb.exp == 8'h00)
      spec_d = SP_INF;
  end

  // Remainder is kept pre-shifted so each step is a single compare/subtract.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    for (int unsigned i = 0; i < UNROLL; i++) begin
      if (rem_d >= {1'b0, mb_q}) begin
        quo_d = {quo_d[24:0], 1'b1};
        rem_d = (rem_d - {1'b0, mb_q}) << 1;
      end else begin
        quo_d = {quo_d[24:0], 1'b0};
        rem_d = rem_d << 1;
      end
    end
  end

  logic signed [9:0] rnd_exp;
  logic [23:0]       rnd_mant;
  logic              rnd_g, rnd_s;
  logic [31:0]       rnd_result;

  always_comb begin
    if (quo_q[25]) begin
      rnd_mant = quo_q[25:2];
      rnd_g    = quo_q[1];
      rnd_s    = quo_q[0] | (rem_q != '0);
      rnd_exp  = exp_q + $signed(10'(EXP_BIAS));
    end else begin
      rnd_mant = quo_q[24:1];
      rnd_g    = quo_q[0];
      rnd_s    = (rem_q != '0);
      rnd_exp  = exp_q + $signed(10'(EXP_BIAS - 1));
    end
  end

  fpu_round u_round (
    .sign_i   (sign_q),
    .exp_i    (rnd_exp),
    .mant_i   (rnd_mant),
    .guard_i  (rnd_g),
    .sticky_i (rnd_s),
    .result_o (rnd_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      spec_q      <= SP_NONE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      rem_q       <= '0;
      mb_q        <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          if (input_valid) begin
            state_q <= S_DIV;
            busy_q  <= 1'b1;
            spec_q  <= spec_d;
            sign_q  <= fa.sign ^ fb.sign;
            exp_q   <= $signed({2'b00, fa.exp}) - $signed({2'b00, fb.exp});
            rem_q   <= {2'b01, fa.frac};
            mb_q    <= {1'b1, fb.frac};
            quo_q   <= '0;
            cnt_q   <= 5'(ITERS);
          end
        end
        S_DIV: begin
          if (cnt_q == '0) begin
            state_q <= S_ROUND;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_ROUND: begin
          state_q     <= S_DONE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          case (spec_q)
            SP_NAN:  result_q <= QNAN;
            SP_ZERO: result_q <= {sign_q, 31'd0};
            SP_INF:  result_q <= {sign_q, PINF[30:0]};
            default: result_q <= rnd_result;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
